// File: rtl/vector_delta_accum_pkg.sv
// Shared types and constants for the lane-serial delta accumulator.
// Saturating accumulation is enabled by defining VECTOR_DELTA_ACCUM_SATURATE_EN.
package vector_delta_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LEN   = 8;

    // Element index width; never narrower than one bit.
    function automatic int idx_w(input int len);
        return ($clog2(len) < 1) ? 1 : $clog2(len);
    endfunction

    localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/vector_delta_accum_if.sv
// Input/output valid-ready bundle of the delta accumulator.
// The master side produces difference vectors and consumes results.
interface vector_delta_accum_if #(
    parameter int WIDTH = 32,
    parameter int LEN   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_load;
    logic [WIDTH-1:0] in_diff [LEN-1:0];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vec [LEN-1:0];

    modport master (
        output in_valid, in_load, in_diff, out_ready,
        input  in_ready, out_valid, out_vec
    );

    modport slave (
        input  in_valid, in_load, in_diff, out_ready,
        output in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/accum_lane_add.sv
// Shared element adder with load bypass.
// VECTOR_DELTA_ACCUM_SATURATE_EN selects signed saturating addition.
module accum_lane_add
    import vector_delta_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_sum
);
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_add;

    assign w_raw = i_a + i_b;

`ifdef VECTOR_DELTA_ACCUM_SATURATE_EN
    localparam logic [WIDTH-1:0] LIM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] LIM_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_ovf;

    // Overflow only when operands share a sign the result lost.
    assign w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                   (w_raw[WIDTH-1] != i_a[WIDTH-1]);
    assign w_add = !w_ovf ? w_raw :
                   (i_a[WIDTH-1] ? LIM_MIN : LIM_MAX);
`else
    assign w_add = w_raw;
`endif

    assign o_sum = i_load ? i_b : w_add;
endmodule

// File: rtl/vector_delta_accum.sv
// Lane-serial vector delta accumulator: acc[i] += diff[i], one element per cycle.
// Build option: VECTOR_DELTA_ACCUM_SATURATE_EN (saturating adds).
module vector_delta_accum
    import vector_delta_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN   = DEF_LEN
) (
    input logic                 clk,
    input logic                 rst,
    vector_delta_accum_if.slave bus
);
    localparam int              IW   = idx_w(LEN);
    localparam logic [IW-1:0]   LAST = IW'(LEN - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic             r_load;
    logic [WIDTH-1:0] r_diff [LEN-1:0];
    logic [WIDTH-1:0] r_acc  [LEN-1:0];
    logic [WIDTH-1:0] w_sum;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_take;

    accum_lane_add #(.WIDTH(WIDTH)) u_add (
        .i_a    (r_acc[r_idx]),
        .i_b    (r_diff[r_idx]),
        .i_load (r_load),
        .o_sum  (w_sum)
    );

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = ACCUM;
            end
            ACCUM: begin
                if (r_idx == LAST) w_next = OUT;
            end
            OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_take        = w_in_ready && bus.in_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_vec   = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_load <= 1'b0;
            for (int i = 0; i < LEN; i++) begin
                r_acc[i]  <= '0;
                r_diff[i] <= '0;
            end
        end else if (w_take) begin
            r_diff <= bus.in_diff;
            r_load <= bus.in_load;
            r_idx  <= '0;
        end else if (r_state == ACCUM) begin
            r_acc[r_idx] <= w_sum;
            r_idx        <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_vector_delta_accum.sv
// Randomized self-checking bench for vector_delta_accum.
// Expected vectors come from an arithmetic reference model of the accumulator.
module tb_vector_delta_accum;
    localparam int W   = 32;
    localparam int LEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W-1:0] mdl [LEN];
    logic [W-1:0] dv  [LEN];

    always #5 clk = ~clk;

    vector_delta_accum_if #(.WIDTH(W), .LEN(LEN)) bus ();

    vector_delta_accum #(.WIDTH(W), .LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] madd(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
`ifdef VECTOR_DELTA_ACCUM_SATURATE_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    task automatic check_vec(input string tag);
        for (int i = 0; i < LEN; i++)
            check($sformatf("%s[%0d]", tag, i), 64'(bus.out_vec[i]),
                  64'(mdl[i]));
    endtask

    // One full transaction: handshake, latency, backpressure, release.
    task automatic xfer(input bit ld, input int hold);
        int n;
        for (int i = 0; i < LEN; i++)
            mdl[i] = ld ? dv[i] : madd(mdl[i], dv[i]);
        bus.in_valid = 1'b1;
        bus.in_load  = ld;
        for (int i = 0; i < LEN; i++) bus.in_diff[i] = dv[i];
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_load = ~ld;
        for (int i = 0; i < LEN; i++) bus.in_diff[i] = $urandom;
        n = 0;
        while (!bus.out_valid && n < 4 * LEN) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 64'(n), 64'(LEN));
        check("busy_ready", 64'(bus.in_ready), 64'd0);
        check_vec("vec");
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_ready", 64'(bus.in_ready), 64'd0);
            check("bp_vec0", 64'(bus.out_vec[0]), 64'(mdl[0]));
            check("bp_vecL", 64'(bus.out_vec[LEN-1]), 64'(mdl[LEN-1]));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("rel_valid", 64'(bus.out_valid), 64'd0);
        check("rel_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic fill(input logic [W-1:0] v);
        for (int i = 0; i < LEN; i++) dv[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_load   = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            bus.in_diff[i] = '0;
            mdl[i] = '0;
        end
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_vec("rst_vec");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < LEN; i++) dv[i] = W'(i + 1);
        xfer(1'b1, 0);
        fill(32'd5);
        xfer(1'b0, 0);
        fill(32'hFFFF_FFFD);
        xfer(1'b0, 1);
        check("acc_minus3", 64'(bus.out_vec[2]), 64'd5);

        fill(32'h7FFF_FFFF);
        xfer(1'b1, 0);
        fill(32'd1);
        xfer(1'b0, 0);
`ifdef VECTOR_DELTA_ACCUM_SATURATE_EN
        check("pos_limit", 64'(bus.out_vec[0]), 64'h7FFF_FFFF);
        fill(32'h8000_0000);
        xfer(1'b1, 0);
        fill(32'hFFFF_FFFF);
        xfer(1'b0, 0);
        check("neg_limit", 64'(bus.out_vec[0]), 64'h8000_0000);
`else
        check("wrap_pos", 64'(bus.out_vec[0]), 64'h8000_0000);
        fill(32'hFFFF_FFFF);
        xfer(1'b1, 0);
        fill(32'd1);
        xfer(1'b0, 0);
        check("wrap_zero", 64'(bus.out_vec[0]), 64'h0);
`endif

        for (int i = 0; i < LEN; i++) dv[i] = $urandom;
        xfer(1'b0, 20);

        // Asynchronous reset while idx is 3 in the middle of accumulation.
        fill(32'd9);
        bus.in_valid = 1'b1;
        bus.in_load  = 1'b1;
        for (int i = 0; i < LEN; i++) bus.in_diff[i] = dv[i];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < LEN; i++) mdl[i] = '0;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        check_vec("mid_rst_vec");
        @(negedge clk);
        rst = 1'b0;
        fill(32'd2);
        xfer(1'b0, 0);
        check("after_rst", 64'(bus.out_vec[LEN-1]), 64'd2);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < LEN; i++) begin
                case ($urandom_range(0, 5))
                    0: dv[i] = 32'h7FFF_FFFF;
                    1: dv[i] = 32'h8000_0000;
                    2: dv[i] = 32'hFFFF_FFFF;
                    default: dv[i] = $urandom;
                endcase
            end
            xfer(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
